// File: rtl/serial_pattern_pkg.sv
// Shared definitions for the serial pattern transmitter: default sizing and FSM state encoding.
package serial_pattern_pkg;

    localparam int DEF_W          = 8;
    localparam int DEF_RPT_W      = 4;
    localparam int DEF_GAP_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/serial_pattern_tx_piso.sv
// Parallel-load, MSB-first shift register with bit counter; keeps a copy of the
// aligned word so each repeat can restart from the first bit.
module piso_shift_reg #(
    parameter int W  = 8,
    parameter int LW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          reload,
    input  logic          shift,
    input  logic [W-1:0]  pattern,
    input  logic [LW-1:0] len,
    output logic          msb,
    output logic          last_bit
);

    logic [W-1:0]  aligned;
    logic [W-1:0]  pat_q;
    logic [W-1:0]  shreg_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] cnt_q;

    // Left-justify so bit len-1 sits at the MSB; unused upper bits fall off.
    assign aligned = pattern << (LW'(W) - len);

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q   <= '0;
            shreg_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            pat_q   <= aligned;
            shreg_q <= aligned;
            len_q   <= len;
            cnt_q   <= '0;
        end else if (reload) begin
            shreg_q <= pat_q;
            cnt_q   <= '0;
        end else if (shift) begin
            shreg_q <= shreg_q << 1;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign msb      = shreg_q[W-1];
    assign last_bit = (cnt_q == len_q - 1'b1);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: accepts a word over valid/ready and sends it
// MSB-first, with optional repeats separated by an idle gap, and abort.
//
//  state | meaning
//  IDLE  | waiting for a command, in_ready high
//  SHIFT | one pattern bit on x per cycle
//  GAP   | idle spacing between repeats, x_valid low
module serial_pattern_tx
    import serial_pattern_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int RPT_W      = DEF_RPT_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    localparam int LW        = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_pattern,
    input  logic [LW-1:0]    in_len,
    input  logic [RPT_W-1:0] in_repeat,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int GAP_W    = (GAP_LOAD > 0) ? $clog2(GAP_LOAD + 1) : 1;

    state_t             state_q, state_d;
    logic [RPT_W-1:0]   rpt_q, rpt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               load, reload, shift;
    logic               msb, last_bit;
    logic               accept, len_ok;

    piso_shift_reg #(.W(W), .LW(LW)) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .reload   (reload),
        .shift    (shift),
        .pattern  (in_pattern),
        .len      (in_len),
        .msb      (msb),
        .last_bit (last_bit)
    );

    // abort outranks a pending command, so the handshake is withheld that cycle
    assign in_ready = (state_q == IDLE) & ~reset & ~abort;
    assign accept   = in_valid & in_ready;
    assign len_ok   = (in_len != '0) && (in_len <= LW'(W));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rpt_q   <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rpt_q   <= rpt_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rpt_d   = rpt_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;
        reload  = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (len_ok) begin
                        load    = 1'b1;
                        rpt_d   = in_repeat;
                        state_d = SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    shift = 1'b1;
                    if (last_bit) begin
                        if (rpt_q == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            rpt_d = rpt_q - 1'b1;
                            if (GAP_CYCLES > 0) begin
                                state_d = GAP;
                                gap_d   = GAP_W'(GAP_LOAD);
                            end else begin
                                reload = 1'b1;
                            end
                        end
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_q == '0) begin
                    state_d = SHIFT;
                    reload  = 1'b1;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign x_valid = (state_q == SHIFT);
    assign x       = x_valid & msb;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed and randomized checks of serial_pattern_tx against a cycle-level
// expectation built from the pattern, length, repeat count and gap length.
module tb_serial_pattern_tx;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_valid0;
    logic       in_ready, in_ready0;
    logic [7:0] in_pattern;
    logic [3:0] in_len;
    logic [3:0] in_repeat;
    logic       abort;
    logic       x, x_valid, busy, done, err;
    logic       x0, x_valid0, busy0, done0, err0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_pattern_tx #(.W(8), .RPT_W(4), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pattern(in_pattern), .in_len(in_len), .in_repeat(in_repeat),
        .abort(abort), .x(x), .x_valid(x_valid), .busy(busy), .done(done), .err(err)
    );

    serial_pattern_tx #(.W(8), .RPT_W(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_pattern(in_pattern), .in_len(in_len), .in_repeat(in_repeat),
        .abort(abort), .x(x0), .x_valid(x_valid0), .busy(busy0), .done(done0), .err(err0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Expected stream: (rep+1) copies of bits len-1..0, GAP idle cycles between copies, then done.
    task automatic run_cmd(input logic [7:0] pat, input int len, input int rep);
        in_pattern = pat;
        in_len     = 4'(len);
        in_repeat  = 4'(rep);
        in_valid   = 1'b1;
        chk("ready_before_cmd", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("no_err_good_len", err, 1'b0);
        for (int r = 0; r <= rep; r++) begin
            for (int i = 0; i < len; i++) begin
                chk("bit_valid", x_valid, 1'b1);
                chk("bit_value", x, pat[len-1-i]);
                chk("busy_shift", busy, 1'b1);
                chk("no_early_done", done, 1'b0);
                step();
            end
            if (r < rep) begin
                for (int g = 0; g < GAP; g++) begin
                    chk("gap_valid", x_valid, 1'b0);
                    chk("gap_x", x, 1'b0);
                    chk("busy_gap", busy, 1'b1);
                    step();
                end
            end
        end
        chk("done_pulse", done, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("idle_valid", x_valid, 1'b0);
        chk("ready_on_done", in_ready, 1'b1);
        step();
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        logic [7:0] q1, q2;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_valid0  = 1'b0;
        in_pattern = '0;
        in_len     = '0;
        in_repeat  = '0;
        abort      = 1'b0;
        step();
        step();
        chk("rst_x", x, 1'b0);
        chk("rst_x_valid", x_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", in_ready, 1'b1);

        run_cmd(8'b0010_1101, 6, 0);
        run_cmd(8'b0010_1101, 6, 1);

        // illegal lengths
        for (int k = 0; k < 2; k++) begin
            in_len   = (k == 0) ? 4'd0 : 4'd9;
            in_valid = 1'b1;
            chk("badlen_ready", in_ready, 1'b1);
            step();
            in_valid = 1'b0;
            chk("badlen_err", err, 1'b1);
            chk("badlen_valid", x_valid, 1'b0);
            chk("badlen_busy", busy, 1'b0);
            chk("badlen_ready_back", in_ready, 1'b1);
            step();
            chk("badlen_err_pulse", err, 1'b0);
            chk("badlen_no_done", done, 1'b0);
        end

        // abort at cycle 3 of an 8-bit send
        in_pattern = 8'hA5;
        in_len     = 4'd8;
        in_repeat  = 4'd0;
        in_valid   = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("abort_pre_valid", x_valid, 1'b1);
        chk("abort_pre_bit", x, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        chk("abort_valid", x_valid, 1'b0);
        chk("abort_x", x, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", in_ready, 1'b1);
        for (int c = 0; c < 8; c++) begin
            chk("abort_no_done", done, 1'b0);
            step();
        end
        run_cmd(8'b1100_1010, 8, 0);

        // abort with a command waiting in IDLE
        in_len   = 4'd3;
        in_valid = 1'b1;
        abort    = 1'b1;
        #1;
        chk("abort_idle_ready", in_ready, 1'b0);
        step();
        in_valid = 1'b0;
        abort    = 1'b0;
        chk("abort_idle_busy", busy, 1'b0);
        chk("abort_idle_err", err, 1'b0);

        // reset during the gap
        in_pattern = 8'b0010_1101;
        in_len     = 4'd6;
        in_repeat  = 4'd1;
        in_valid   = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) step();
        chk("midgap_valid", x_valid, 1'b0);
        chk("midgap_busy", busy, 1'b1);
        reset = 1'b1;
        step();
        chk("rstgap_x", x, 1'b0);
        chk("rstgap_valid", x_valid, 1'b0);
        chk("rstgap_busy", busy, 1'b0);
        chk("rstgap_done", done, 1'b0);
        chk("rstgap_ready", in_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("rstgap_ready_after", in_ready, 1'b1);
        for (int c = 0; c < 10; c++) begin
            chk("rstgap_no_resume", x_valid, 1'b0);
            chk("rstgap_no_done", done, 1'b0);
            step();
        end

        // back-to-back commands with in_valid held high
        q1 = 8'b0000_0101;
        q2 = 8'b0000_0010;
        in_pattern = q1;
        in_len     = 4'd3;
        in_repeat  = 4'd0;
        in_valid   = 1'b1;
        step();
        in_pattern = q2;
        in_len     = 4'd2;
        for (int i = 0; i < 3; i++) begin
            chk("q1_valid", x_valid, 1'b1);
            chk("q1_bit", x, q1[2-i]);
            chk("q1_not_ready", in_ready, 1'b0);
            step();
        end
        chk("q1_done", done, 1'b1);
        chk("q_bubble", x_valid, 1'b0);
        chk("q2_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("q2_valid", x_valid, 1'b1);
            chk("q2_bit", x, q2[1-i]);
            step();
        end
        chk("q2_done", done, 1'b1);
        step();

        // zero-gap instance: three consecutive single-bit sends
        in_pattern = 8'h01;
        in_len     = 4'd1;
        in_repeat  = 4'd2;
        in_valid0  = 1'b1;
        chk("g0_ready", in_ready0, 1'b1);
        step();
        in_valid0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("g0_valid", x_valid0, 1'b1);
            chk("g0_bit", x0, 1'b1);
            chk("g0_busy", busy0, 1'b1);
            step();
        end
        chk("g0_done", done0, 1'b1);
        chk("g0_idle", busy0, 1'b0);
        chk("g0_err", err0, 1'b0);
        step();

        // maximum repeat count must give 16 sends without wrapping
        run_cmd(8'b0000_0010, 2, 15);

        for (int n = 0; n < 12; n++) begin
            run_cmd(8'($urandom), int'($urandom_range(1, 8)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
